mist1032isa_sync_fifo_th: RTL and testbench

Single-clock, parametrised FIFO for buffering between pipeline stages of the MIST1032ISA core, e.g. fetch-to-decode and load/store queues. It provides first-word-fall-through read data, full and empty flags, and programmable almost-full and almost-empty thresholds. Illegal pushes and pops are guarded, with optional sticky error flags. An exact occupancy count is reported over the full range 0..DEPTH.

---
 rtl/mist1032isa_fifo_pkg.sv | 37 +++
 rtl/mist1032isa_sync_fifo_ram.sv | 30 +++
 rtl/mist1032isa_sync_fifo_th.sv | 135 +++++++++++++
 tb/tb_mist1032isa_sync_fifo_th.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mist1032isa_fifo_pkg.sv
// Shared definitions for the MIST1032ISA synchronous FIFOs: pointer-width helper,
// default thresholds and a parameter sanity check used at elaboration.
package mist1032isa_fifo_pkg;

    localparam int DEF_N         = 16;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_AFULL_TH  = 3;
    localparam int DEF_AEMPTY_TH = 1;

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_PUSH = 2'b01,
        FIFO_POP  = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << width) < value) begin
                width = width + 1;
            end
        end
        return width;
    endfunction

    // Depth must be an exact power of two matching D_N so the extra pointer bit
    // distinguishes full from empty; thresholds must be reachable occupancies.
    function automatic bit params_ok(input int depth, input int d_n,
                                     input int afull_th, input int aempty_th);
        return (depth >= 2) && (depth == (1 << d_n)) && (clog2(depth) == d_n) &&
               (afull_th >= 1) && (afull_th <= depth) &&
               (aempty_th >= 0) && (aempty_th <= depth - 1);
    endfunction

endpackage

// File: rtl/mist1032isa_sync_fifo_ram.sv
// DEPTH x N storage for the synchronous FIFO: registered write port,
// asynchronous read port so the head word falls through without latency.
module mist1032isa_sync_fifo_ram
    import mist1032isa_fifo_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int DEPTH = DEF_DEPTH,
    parameter int D_N   = 2
) (
    input  logic           iCLOCK,
    input  logic           iWR_EN,
    input  logic [D_N-1:0] iWR_ADDR,
    input  logic [N-1:0]   iWR_DATA,
    input  logic [D_N-1:0] iRD_ADDR,
    output logic [N-1:0]   oRD_DATA
);

    logic [N-1:0] mem [DEPTH];

    // NOTE: storage is deliberately left out of reset; the pointers alone define
    // which entries are valid, and a reset term would turn the array into flops.
    always_ff @(posedge iCLOCK) begin
        if (iWR_EN) begin
            mem[iWR_ADDR] <= iWR_DATA;
        end
    end

    assign oRD_DATA = mem[iRD_ADDR];

endmodule

// File: rtl/mist1032isa_sync_fifo_th.sv
// Single-clock first-word-fall-through FIFO with almost-full/almost-empty thresholds.
// Optional sticky overflow/underflow flags: define MIST1032ISA_SYNC_FIFO_ERRCHK_EN.
module mist1032isa_sync_fifo_th
    import mist1032isa_fifo_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int D_N       = 2,
    parameter int AFULL_TH  = DEF_AFULL_TH,
    parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
    input  logic         iCLOCK,
    input  logic         iRESET,
    input  logic         iREMOVE,
    output logic [D_N:0] oCOUNT,
    input  logic         iWR_EN,
    input  logic [N-1:0] iWR_DATA,
    output logic         oWR_FULL,
    output logic         oWR_AFULL,
    input  logic         iRD_EN,
    output logic [N-1:0] oRD_DATA,
    output logic         oRD_EMPTY,
    output logic         oRD_AEMPTY,
    output logic         oOVERFLOW,
    output logic         oUNDERFLOW
);

    if (!params_ok(DEPTH, D_N, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
        $error("mist1032isa_sync_fifo_th: inconsistent DEPTH/D_N or threshold out of range");
    end

    localparam logic [D_N:0] PTR_ONE    = 1;
    localparam logic [D_N:0] AFULL_LVL  = AFULL_TH[D_N:0];
    localparam logic [D_N:0] AEMPTY_LVL = AEMPTY_TH[D_N:0];

    logic [D_N:0] wrPtr;
    logic [D_N:0] rdPtr;
    logic [D_N:0] wrPtrNext;
    logic [D_N:0] rdPtrNext;
    logic [D_N:0] count;
    logic         full;
    logic         empty;
    logic         pushOk;
    logic         popOk;
    fifo_op_e     op;

    // Pointers carry one extra wrap bit, so the modular difference spans 0..DEPTH.
    assign count  = wrPtr - rdPtr;
    assign full   = count[D_N];
    assign empty  = (count == '0);

    assign popOk  = iRD_EN && !empty;
    assign pushOk = iWR_EN && (!full || popOk);
    assign op     = fifo_op_e'({popOk, pushOk});

    // NOTE: every combinational output gets a default first, so no path
    // through the case statement can leave a value held (no latch).
    always_comb begin
        wrPtrNext = wrPtr;
        rdPtrNext = rdPtr;
        if (iREMOVE) begin
            wrPtrNext = '0;
            rdPtrNext = '0;
        end else begin
            case (op)
                FIFO_PUSH: wrPtrNext = wrPtr + PTR_ONE;
                FIFO_POP:  rdPtrNext = rdPtr + PTR_ONE;
                FIFO_BOTH: begin
                    wrPtrNext = wrPtr + PTR_ONE;
                    rdPtrNext = rdPtr + PTR_ONE;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            wrPtr <= wrPtrNext;
            rdPtr <= rdPtrNext;
        end
    end

    // When full, a simultaneous pop frees the slot being written; the old head is
    // read combinationally this cycle and overwritten at the edge.
    mist1032isa_sync_fifo_ram #(
        .N     (N),
        .DEPTH (DEPTH),
        .D_N   (D_N)
    ) u_ram (
        .iCLOCK   (iCLOCK),
        .iWR_EN   (pushOk && !iREMOVE),
        .iWR_ADDR (wrPtr[D_N-1:0]),
        .iWR_DATA (iWR_DATA),
        .iRD_ADDR (rdPtr[D_N-1:0]),
        .oRD_DATA (oRD_DATA)
    );

`ifdef MIST1032ISA_SYNC_FIFO_ERRCHK_EN
    logic overflow;
    logic underflow;

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (iWR_EN && !pushOk) begin
                overflow <= 1'b1;
            end
            if (iRD_EN && !popOk && !iREMOVE) begin
                underflow <= 1'b1;
            end
        end
    end

    assign oOVERFLOW  = overflow;
    assign oUNDERFLOW = underflow;
`else
    assign oOVERFLOW  = 1'b0;
    assign oUNDERFLOW = 1'b0;
`endif

    assign oCOUNT     = count;
    assign oWR_FULL   = full;
    assign oWR_AFULL  = (count >= AFULL_LVL);
    assign oRD_EMPTY  = empty;
    assign oRD_AEMPTY = (count <= AEMPTY_LVL);

endmodule

// File: tb/tb_mist1032isa_sync_fifo_th.sv
// Self-checking bench for mist1032isa_sync_fifo_th: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_mist1032isa_sync_fifo_th;

    localparam int N         = 16;
    localparam int DEPTH     = 4;
    localparam int D_N       = 2;
    localparam int AFULL_TH  = 3;
    localparam int AEMPTY_TH = 1;

`ifdef MIST1032ISA_SYNC_FIFO_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic         iCLOCK;
    logic         iRESET;
    logic         iREMOVE;
    logic [D_N:0] oCOUNT;
    logic         iWR_EN;
    logic [N-1:0] iWR_DATA;
    logic         oWR_FULL;
    logic         oWR_AFULL;
    logic         iRD_EN;
    logic [N-1:0] oRD_DATA;
    logic         oRD_EMPTY;
    logic         oRD_AEMPTY;
    logic         oOVERFLOW;
    logic         oUNDERFLOW;

    int total;
    int bad;

    logic [N-1:0] modelQ [$];
    bit           modelOvf;
    bit           modelUnf;

    mist1032isa_sync_fifo_th #(
        .N         (N),
        .DEPTH     (DEPTH),
        .D_N       (D_N),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) dut (
        .iCLOCK     (iCLOCK),
        .iRESET     (iRESET),
        .iREMOVE    (iREMOVE),
        .oCOUNT     (oCOUNT),
        .iWR_EN     (iWR_EN),
        .iWR_DATA   (iWR_DATA),
        .oWR_FULL   (oWR_FULL),
        .oWR_AFULL  (oWR_AFULL),
        .iRD_EN     (iRD_EN),
        .oRD_DATA   (oRD_DATA),
        .oRD_EMPTY  (oRD_EMPTY),
        .oRD_AEMPTY (oRD_AEMPTY),
        .oOVERFLOW  (oOVERFLOW),
        .oUNDERFLOW (oUNDERFLOW)
    );

    initial begin
        iCLOCK = 1'b0;
        forever #5 iCLOCK = ~iCLOCK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model; head data only when non-empty.
    task automatic check_all(input string tag);
        int sz;
        sz = modelQ.size();
        check({tag, ".count"},  32'(oCOUNT),     32'(sz));
        check({tag, ".empty"},  32'(oRD_EMPTY),  32'(sz == 0));
        check({tag, ".full"},   32'(oWR_FULL),   32'(sz == DEPTH));
        check({tag, ".afull"},  32'(oWR_AFULL),  32'(sz >= AFULL_TH));
        check({tag, ".aempty"}, 32'(oRD_AEMPTY), 32'(sz <= AEMPTY_TH));
        check({tag, ".ovf"},    32'(oOVERFLOW),  32'(ERRCHK && modelOvf));
        check({tag, ".unf"},    32'(oUNDERFLOW), 32'(ERRCHK && modelUnf));
        if (sz > 0) begin
            check({tag, ".data"}, 32'(oRD_DATA), 32'(modelQ[0]));
        end
    endtask

    // One clock cycle of stimulus, entered and left just after a falling edge.
    task automatic step(input bit wr, input logic [N-1:0] data, input bit rd,
                        input bit rem, input string tag);
        int  sz;
        bit  popAcc;
        bit  pushAcc;
        iWR_EN   = wr;
        iWR_DATA = data;
        iRD_EN   = rd;
        iREMOVE  = rem;
        sz       = modelQ.size();
        popAcc   = rd && (sz > 0);
        pushAcc  = wr && ((sz < DEPTH) || popAcc);
        if (wr && !pushAcc) modelOvf = 1'b1;
        if (rd && !popAcc && !rem) modelUnf = 1'b1;
        if (rem) begin
            modelQ.delete();
        end else begin
            if (popAcc) void'(modelQ.pop_front());
            if (pushAcc) modelQ.push_back(data);
        end
        @(posedge iCLOCK);
        @(negedge iCLOCK);
        iWR_EN  = 1'b0;
        iRD_EN  = 1'b0;
        iREMOVE = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset();
        iRESET = 1'b1;
        @(posedge iCLOCK);
        @(negedge iCLOCK);
        iRESET = 1'b0;
        modelQ.delete();
        modelOvf = 1'b0;
        modelUnf = 1'b0;
        check_all("reset");
    endtask

    initial begin
        logic [N-1:0] pattern [4];
        logic [N-1:0] word;
        logic [N-1:0] seq;
        bit           wr;
        bit           rd;
        total    = 0;
        bad      = 0;
        iRESET   = 1'b1;
        iREMOVE  = 1'b0;
        iWR_EN   = 1'b0;
        iRD_EN   = 1'b0;
        iWR_DATA = '0;
        pattern[0] = 16'h1111;
        pattern[1] = 16'h2222;
        pattern[2] = 16'h3333;
        pattern[3] = 16'h4444;
        @(negedge iCLOCK);
        @(negedge iCLOCK);
        do_reset();

        // Fill to full, head stays the first word.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, pattern[i], 1'b0, 1'b0, "fill");
            check("fill.head", 32'(oRD_DATA), 32'h1111);
        end
        check("fill.full", 32'(oWR_FULL), 32'd1);

        // Push at full without pop is dropped.
        step(1'b1, 16'h5555, 1'b0, 1'b0, "drop");
        check("drop.count", 32'(oCOUNT), 32'd4);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            check("drain.data", 32'(oRD_DATA), 32'(pattern[i]));
            step(1'b0, '0, 1'b1, 1'b0, "drain");
        end
        check("drain.empty", 32'(oRD_EMPTY), 32'd1);

        // Full push+pop reuses the freed slot; overflow must stay clear.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, pattern[i], 1'b0, 1'b0, "refill");
        check("both.oldhead", 32'(oRD_DATA), 32'h1111);
        step(1'b1, 16'hAAAA, 1'b1, 1'b0, "both");
        check("both.ovf", 32'(oOVERFLOW), 32'd0);
        for (int i = 0; i < 4; i++) begin
            word = modelQ[0];
            check("both.drain", 32'(oRD_DATA), 32'(word));
            step(1'b0, '0, 1'b1, 1'b0, "bothdrain");
        end
        check("both.last", 32'(word), 32'hAAAA);

        // Empty push+pop: push accepted, pop ignored.
        do_reset();
        step(1'b1, 16'hBEEF, 1'b1, 1'b0, "emptyboth");
        check("emptyboth.data", 32'(oRD_DATA), 32'hBEEF);
        check("emptyboth.unf", 32'(oUNDERFLOW), 32'(ERRCHK));

        // Interleaved traffic across the pointer wrap, occupancy 1..3.
        do_reset();
        seq = 16'h0100;
        step(1'b1, seq, 1'b0, 1'b0, "wrap0");
        for (int i = 0; i < 10; i++) begin
            seq++;
            wr = (modelQ.size() < 3);
            rd = (modelQ.size() > 1) || (i % 2 == 1);
            step(wr, seq, rd, 1'b0, "wrap");
            check("wrap.max", 32'(oCOUNT <= 3'd4), 32'd1);
        end

        // Flush with a concurrent push discards everything.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, pattern[i], 1'b0, 1'b0, "pre");
        step(1'b1, 16'h7777, 1'b0, 1'b1, "flush");
        check("flush.count", 32'(oCOUNT), 32'd0);

        // Asynchronous reset mid-cycle with sticky flags set.
        for (int i = 0; i < 3; i++) step(1'b1, pattern[i], 1'b0, 1'b0, "pre2");
        step(1'b0, '0, 1'b1, 1'b1, "flushrd");
        step(1'b0, '0, 1'b1, 1'b0, "setunf");
        for (int i = 0; i < 4; i++) step(1'b1, pattern[i], 1'b0, 1'b0, "pre3");
        step(1'b1, 16'h9999, 1'b0, 1'b0, "setovf");
        #2;
        iRESET = 1'b1;
        #1;
        check("areset.count", 32'(oCOUNT), 32'd0);
        check("areset.empty", 32'(oRD_EMPTY), 32'd1);
        check("areset.ovf", 32'(oOVERFLOW), 32'd0);
        check("areset.unf", 32'(oUNDERFLOW), 32'd0);
        #1;
        iRESET = 1'b0;
        modelQ.delete();
        modelOvf = 1'b0;
        modelUnf = 1'b0;
        @(negedge iCLOCK);
        check_all("postreset");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), N'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 31) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
